apb_initiator: RTL and testbench

// - APB requester (source end of apb_if): turns a single-outstanding valid/ready command stream into APB

---
 rtl/apb_initiator_pkg.sv | 30 +++
 rtl/apb_if.sv | 23 ++
 rtl/apb_init_timeout.sv | 30 +++
 rtl/apb_initiator.sv | 122 ++++++++++++
 tb/tb_apb_initiator.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator and its APB bus interface.
package apb_initiator_pkg;

    localparam int APB_ADDR_W               = 32;
    localparam int APB_DATA_W               = 32;
    localparam int APB_INIT_WAIT_W          = 16;
    localparam int APB_INIT_TIMEOUT_DEFAULT = 256;

    typedef logic [APB_ADDR_W-1:0] apbAddrT;
    typedef logic [APB_DATA_W-1:0] apbDataT;

    typedef struct packed {
        apbAddrT addr;
        apbDataT data;
        logic    write;
    } apbInitReqSt;

    typedef struct packed {
        apbDataT rdata;
        logic    err;
    } apbInitRspSt;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apbInitStateE;

endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle; the requester uses modport src, a completer uses modport dst.
interface apb_if;
    import apb_initiator_pkg::*;

    apbAddrT paddr;
    logic    psel;
    logic    penable;
    logic    pwrite;
    apbDataT pwdata;
    apbDataT prdata;
    logic    pready;
    logic    pslverr;

    modport src (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport dst (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_init_timeout.sv
// ACCESS-phase wait counter; flags the cycle on which a stalled transfer must be aborted.
module apb_init_timeout
    import apb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_INIT_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam logic [APB_INIT_WAIT_W-1:0] LIMIT = APB_INIT_WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [APB_INIT_WAIT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (waiting) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = waiting && (count_reg == LIMIT);

endmodule

// File: rtl/apb_initiator.sv
// APB requester: one valid/ready command in, one SETUP/ACCESS transfer, one response out.
// Define APB_INIT_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES cycles.
module apb_initiator
    import apb_initiator_pkg::*;
#(
`ifdef APB_INIT_TIMEOUT_EN
    parameter int      TIMEOUT_CYCLES = APB_INIT_TIMEOUT_DEFAULT,
`endif
    parameter apbAddrT APB_ADDR_MASK  = 32'h00ff_ffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  apbInitReqSt req,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output apbInitRspSt rsp,
    apb_if.src          apbReg,
    output logic        timeout_evt
);

    apbInitStateE state_reg;
    logic         req_ready_reg;
    logic         rsp_valid_reg;
    apbInitRspSt  rsp_reg;
    logic         timeout_evt_reg;
    logic         psel_reg;
    logic         penable_reg;
    logic         pwrite_reg;
    apbAddrT      paddr_reg;
    apbDataT      pwdata_reg;
    logic         timeout_hit;

`ifdef APB_INIT_TIMEOUT_EN
    apb_init_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg == SETUP),
        .waiting (state_reg == ACCESS && !apbReg.pready),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // The APB address/data/direction registers double as the command holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_reg         <= '0;
            timeout_evt_reg <= 1'b0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
        end else begin
            timeout_evt_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        psel_reg      <= 1'b1;
                        penable_reg   <= 1'b0;
                        paddr_reg     <= req.addr & APB_ADDR_MASK;
                        pwrite_reg    <= req.write;
                        pwdata_reg    <= req.write ? req.data : '0;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    // A completing pready takes priority over a same-cycle timeout.
                    if (apbReg.pready) begin
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_reg.rdata <= pwrite_reg ? '0 : apbReg.prdata;
                        rsp_reg.err   <= apbReg.pslverr;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else if (timeout_hit) begin
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        rsp_reg.rdata   <= '0;
                        rsp_reg.err     <= 1'b1;
                        rsp_valid_reg   <= 1'b1;
                        timeout_evt_reg <= 1'b1;
                        state_reg       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp            = rsp_reg;
    assign timeout_evt    = timeout_evt_reg;
    assign apbReg.psel    = psel_reg;
    assign apbReg.penable = penable_reg;
    assign apbReg.pwrite  = pwrite_reg;
    assign apbReg.paddr   = paddr_reg;
    assign apbReg.pwdata  = pwdata_reg;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed and randomized transfers against a transaction-level model of the APB initiator.
`timescale 1ns/1ps
module tb_apb_initiator;
    import apb_initiator_pkg::*;

    localparam apbAddrT MASK   = 32'h00ff_ffff;
    localparam apbDataT RD_KEY = 32'h5a5a_c3c3;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    apbInitReqSt req       = '0;
    logic        req_ready;
    logic        rsp_valid;
    apbInitRspSt rsp;
    logic        timeout_evt;

    int checks = 0;
    int errors = 0;

    apb_if apb_bus ();

    always #5 clk = ~clk;

    apb_initiator #(
`ifdef APB_INIT_TIMEOUT_EN
        .TIMEOUT_CYCLES (8),
`endif
        .APB_ADDR_MASK  (32'h00ff_ffff)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req         (req),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp         (rsp),
        .apbReg      (apb_bus),
        .timeout_evt (timeout_evt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("idle_wait_req_ready", req_ready, 1);
    endtask

    // One full transfer; expectations come straight from the transfer rules.
    task automatic run_txn(input apbAddrT addr, input apbDataT data, input logic wr,
                           input int waits, input apbDataT rd_in, input logic slverr,
                           input int rsp_delay);
        apbAddrT exp_paddr  = addr & MASK;
        apbDataT exp_pwdata = wr ? data : '0;
        apbDataT exp_rdata  = wr ? '0 : rd_in;
        wait_idle();
        req_valid = 1'b1;
        req = '{addr: addr, data: data, write: wr};
        tick();
        req_valid = 1'b0;
        req = '{addr: $urandom, data: $urandom, write: 1'($urandom)};
        check("setup_psel", apb_bus.psel, 1);
        check("setup_penable", apb_bus.penable, 0);
        check("setup_paddr", apb_bus.paddr, exp_paddr);
        check("setup_pwrite", apb_bus.pwrite, wr);
        check("setup_pwdata", apb_bus.pwdata, exp_pwdata);
        check("setup_req_ready", req_ready, 0);
        tick();
        for (int i = 0; i <= waits; i++) begin
            check("access_psel", apb_bus.psel, 1);
            check("access_penable", apb_bus.penable, 1);
            check("access_paddr", apb_bus.paddr, exp_paddr);
            check("access_pwdata", apb_bus.pwdata, exp_pwdata);
            check("access_rsp_valid", rsp_valid, 0);
            apb_bus.pready  = (i == waits);
            apb_bus.prdata  = (i == waits) ? rd_in : apbDataT'($urandom);
            apb_bus.pslverr = (i == waits) ? slverr : 1'($urandom);
            tick();
        end
        apb_bus.pready  = 1'b0;
        apb_bus.prdata  = $urandom;
        apb_bus.pslverr = 1'($urandom);
        check("resp_psel", apb_bus.psel, 0);
        check("resp_penable", apb_bus.penable, 0);
        check("resp_valid", rsp_valid, 1);
        check("resp_rdata", rsp.rdata, exp_rdata);
        check("resp_err", rsp.err, slverr);
        check("resp_timeout_evt", timeout_evt, 0);
        for (int k = 0; k < rsp_delay; k++) begin
            rsp_ready = 1'b0;
            tick();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rdata", rsp.rdata, exp_rdata);
            check("bp_err", rsp.err, slverr);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_req_ready", req_ready, 1);
        $display("txn %s addr=%h data=%h waits=%0d slverr=%0d rsp_delay=%0d rdata=%h",
                 wr ? "WR" : "RD", addr, data, waits, slverr, rsp_delay, exp_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts[$];
        apbDataT exp_q[$];
        int overlaps;
        int rsp_seen;
        int sent;
        logic accepting;

        apb_bus.pready  = 1'b0;
        apb_bus.prdata  = '0;
        apb_bus.pslverr = 1'b0;

        // Reset state
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp", rsp.rdata, 0);
        check("rst_rsp_err", rsp.err, 0);
        check("rst_psel", apb_bus.psel, 0);
        check("rst_penable", apb_bus.penable, 0);
        check("rst_pwrite", apb_bus.pwrite, 0);
        check("rst_paddr", apb_bus.paddr, 0);
        check("rst_pwdata", apb_bus.pwdata, 0);
        check("rst_timeout_evt", timeout_evt, 0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", req_ready, 1);

        // Directed transfers
        run_txn(32'h0100_0040, 32'hdead_beef, 1'b1, 0, 32'h0, 1'b0, 0);
        run_txn(32'h0000_1234, 32'h0, 1'b0, 3, 32'h1b45_f720, 1'b0, 0);
        run_txn(32'h00ab_0008, 32'h0, 1'b0, 1, 32'h7777_0001, 1'b1, 5);

        // Back-to-back commands with req_valid held high
        wait_idle();
        apb_bus.pready = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req = '{addr: $urandom, data: $urandom, write: 1'b0};
        overlaps = 0;
        rsp_seen = 0;
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            apb_bus.prdata = apb_bus.paddr ^ RD_KEY;
            if (apb_bus.psel && rsp_valid) overlaps++;
            if (rsp_valid) begin
                rsp_seen++;
                if (exp_q.size() == 0) check("b2b_spurious_rsp", 1, 0);
                else check("b2b_rdata", rsp.rdata, exp_q.pop_front());
            end
            accepting = req_valid && req_ready;
            if (accepting) begin
                accepts.push_back(c);
                exp_q.push_back((req.addr & MASK) ^ RD_KEY);
            end
            tick();
            if (accepting) begin
                sent++;
                if (sent == 3) req_valid = 1'b0;
                else req = '{addr: $urandom, data: $urandom, write: 1'b0};
            end
        end
        apb_bus.pready = 1'b0;
        rsp_ready = 1'b0;
        check("b2b_accepts", accepts.size(), 3);
        if (accepts.size() == 3) begin
            check("b2b_gap1", accepts[1] - accepts[0], 4);
            check("b2b_gap2", accepts[2] - accepts[1], 4);
        end
        check("b2b_overlap", overlaps, 0);
        check("b2b_rsp_count", rsp_seen, 3);
        $display("txn B2B accepts=%0d responses=%0d", accepts.size(), rsp_seen);

        // Reset pulsed during ACCESS
        wait_idle();
        req_valid = 1'b1;
        req = '{addr: 32'h0000_0200, data: 32'h0, write: 1'b0};
        tick();
        req_valid = 1'b0;
        tick();
        check("rstmid_access_penable", apb_bus.penable, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_psel", apb_bus.psel, 0);
        check("rstmid_penable", apb_bus.penable, 0);
        check("rstmid_req_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        apb_bus.pready = 1'b1;
        apb_bus.prdata = 32'h0bad_0bad;
        for (int c = 0; c < 6; c++) begin
            check("rstmid_no_rsp", rsp_valid, 0);
            check("rstmid_no_psel", apb_bus.psel, 0);
            tick();
        end
        apb_bus.pready = 1'b0;
        $display("txn RST mid-access discarded");
        run_txn(32'h0000_0300, 32'hcafe_f00d, 1'b1, 2, 32'h0, 1'b0, 1);

`ifdef APB_INIT_TIMEOUT_EN
        begin
            int access_cycles = 0;
            int pulses = 0;
            wait_idle();
            req_valid = 1'b1;
            req = '{addr: 32'h0000_0400, data: 32'h0, write: 1'b0};
            tick();
            req_valid = 1'b0;
            tick();
            apb_bus.pready = 1'b0;
            apb_bus.prdata = 32'h1111_2222;
            while (apb_bus.psel && apb_bus.penable && access_cycles < 40) begin
                access_cycles++;
                tick();
                if (timeout_evt) pulses++;
            end
            check("to_access_cycles", access_cycles, 8);
            check("to_rsp_valid", rsp_valid, 1);
            check("to_rsp_err", rsp.err, 1);
            check("to_rsp_rdata", rsp.rdata, 0);
            rsp_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (timeout_evt) pulses++;
            end
            rsp_ready = 1'b0;
            check("to_pulses", pulses, 1);
            $display("txn TIMEOUT access_cycles=%0d pulses=%0d", access_cycles, pulses);

            pulses = 0;
            wait_idle();
            req_valid = 1'b1;
            req = '{addr: 32'h0000_0404, data: 32'h0, write: 1'b0};
            tick();
            req_valid = 1'b0;
            tick();
            for (int i = 0; i < 8; i++) begin
                check("late_access_psel", apb_bus.psel, 1);
                apb_bus.pready  = (i == 7);
                apb_bus.prdata  = 32'h2468_ace0;
                apb_bus.pslverr = 1'b0;
                tick();
                if (timeout_evt) pulses++;
            end
            apb_bus.pready = 1'b0;
            check("late_rsp_valid", rsp_valid, 1);
            check("late_rsp_err", rsp.err, 0);
            check("late_rsp_rdata", rsp.rdata, 32'h2468_ace0);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("late_pulses", pulses, 0);
            $display("txn LATE-READY pulses=%0d", pulses);
        end
`endif

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            run_txn(apbAddrT'($urandom), apbDataT'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), apbDataT'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
